// File: rtl/oflow_score_feeder.sv
// oflow_score_feeder
// Streams candidate scores into an external running-minimum calculator two
// at a time. An odd final candidate is paired with a MAX_SCORE/ID-0 pad,
// which the calculator never prefers over a real candidate. When all pairs
// have been compared, the calculator's best and second-best are captured
// and announced with a one-cycle res_valid strobe.
// Note: reset_N is active-high despite its name.

module oflow_score_feeder #(
  parameter int SCORE_LEN = 16,
  parameter int ID_LEN    = 12,
  parameter int CNT_LEN   = 8
) (
  input  logic                 clk,
  input  logic                 reset_N,
  input  logic                 start_pair_search,
  input  logic [CNT_LEN-1:0]   num_candidates,
  input  logic                 cand_valid,
  output logic                 cand_ready,
  input  logic [SCORE_LEN-1:0] cand_score,
  input  logic [ID_LEN-1:0]    cand_id,
  output logic                 start_score_calc,
  output logic                 start_calc_min,
  input  logic                 done_calc_min,
  output logic [SCORE_LEN-1:0] score_0,
  output logic [SCORE_LEN-1:0] score_1,
  output logic [ID_LEN-1:0]    id_0,
  output logic [ID_LEN-1:0]    id_1,
  input  logic [SCORE_LEN-1:0] min_score_0,
  input  logic [SCORE_LEN-1:0] min_score_1,
  input  logic [ID_LEN-1:0]    min_id_0,
  input  logic [ID_LEN-1:0]    min_id_1,
  output logic                 res_valid,
  output logic [SCORE_LEN-1:0] res_score_0,
  output logic [SCORE_LEN-1:0] res_score_1,
  output logic [ID_LEN-1:0]    res_id_0,
  output logic [ID_LEN-1:0]    res_id_1,
  output logic                 busy
);

  localparam logic [SCORE_LEN-1:0] MAX_SCORE = '1;
  localparam logic [CNT_LEN-1:0]   CNT_ONE   = CNT_LEN'(1);

  typedef enum logic [2:0] {
    IDLE,
    CLEAR,
    COLLECT0,
    COLLECT1,
    ISSUE,
    WAIT_DONE,
    REPORT
  } state_t;

  state_t             state;
  state_t             state_next;
  logic [CNT_LEN-1:0] remaining;
  logic               handshake;

  assign handshake = cand_valid && cand_ready;

  // State register; reset returns to IDLE so the next search starts with CLEAR.
  always_ff @(posedge clk or posedge reset_N) begin
    if (reset_N) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  // Next-state and state-decoded strobes; strobes are zero in IDLE so reset clears them.
  always_comb begin
    state_next       = state;
    cand_ready       = 1'b0;
    start_score_calc = 1'b0;
    start_calc_min   = 1'b0;
    busy             = 1'b1;
    case (state)
      IDLE: begin
        busy = 1'b0;
        if (start_pair_search) begin
          state_next = CLEAR;
        end
      end
      CLEAR: begin
        start_score_calc = 1'b1;
        state_next       = (remaining == '0) ? REPORT : COLLECT0;
      end
      COLLECT0: begin
        cand_ready = 1'b1;
        if (cand_valid) begin
          state_next = (remaining == CNT_ONE) ? ISSUE : COLLECT1;
        end
      end
      COLLECT1: begin
        cand_ready = 1'b1;
        if (cand_valid) begin
          state_next = ISSUE;
        end
      end
      ISSUE: begin
        start_calc_min = 1'b1;
        state_next     = WAIT_DONE;
      end
      WAIT_DONE: begin
        if (done_calc_min) begin
          state_next = (remaining == '0) ? REPORT : COLLECT0;
        end
      end
      REPORT: begin
        state_next = IDLE;
      end
      default: begin
        state_next = IDLE;
      end
    endcase
  end

  // Candidate counter and pair registers; pair values only move during collection so they stay stable across a compare.
  always_ff @(posedge clk or posedge reset_N) begin
    if (reset_N) begin
      remaining <= '0;
      score_0   <= '0;
      score_1   <= '0;
      id_0      <= '0;
      id_1      <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (start_pair_search) begin
            remaining <= num_candidates;
          end
        end
        COLLECT0: begin
          if (handshake) begin
            score_0   <= cand_score;
            id_0      <= cand_id;
            remaining <= remaining - CNT_ONE;
            if (remaining == CNT_ONE) begin
              score_1 <= MAX_SCORE;
              id_1    <= '0;
            end
          end
        end
        COLLECT1: begin
          if (handshake) begin
            score_1   <= cand_score;
            id_1      <= cand_id;
            remaining <= remaining - CNT_ONE;
          end
        end
        default: begin
        end
      endcase
    end
  end

  // Result capture on leaving REPORT; the strobe rises together with the newly captured values.
  always_ff @(posedge clk or posedge reset_N) begin
    if (reset_N) begin
      res_valid   <= 1'b0;
      res_score_0 <= '0;
      res_score_1 <= '0;
      res_id_0    <= '0;
      res_id_1    <= '0;
    end else begin
      res_valid <= (state == REPORT);
      if (state == REPORT) begin
        res_score_0 <= min_score_0;
        res_id_0    <= min_id_0;
        res_score_1 <= min_score_1;
        res_id_1    <= min_id_1;
      end
    end
  end

endmodule

// File: tb/tb_oflow_score_feeder.sv
// tb_oflow_score_feeder
// Directed bench for oflow_score_feeder with a behavioural top-2 minimum
// calculator attached; expected results are hand-computed per step.

module tb_oflow_score_feeder;

  logic        clk = 1'b0;
  logic        reset_N;
  logic        start_pair_search;
  logic [7:0]  num_candidates;
  logic        cand_valid;
  logic        cand_ready;
  logic [15:0] cand_score;
  logic [11:0] cand_id;
  logic        start_score_calc;
  logic        start_calc_min;
  logic        done_calc_min;
  logic [15:0] score_0, score_1;
  logic [11:0] id_0, id_1;
  logic [15:0] min_score_0, min_score_1;
  logic [11:0] min_id_0, min_id_1;
  logic        res_valid;
  logic [15:0] res_score_0, res_score_1;
  logic [11:0] res_id_0, res_id_1;
  logic        busy;

  int total = 0;
  int bad   = 0;

  oflow_score_feeder dut (
    .clk              (clk),
    .reset_N          (reset_N),
    .start_pair_search(start_pair_search),
    .num_candidates   (num_candidates),
    .cand_valid       (cand_valid),
    .cand_ready       (cand_ready),
    .cand_score       (cand_score),
    .cand_id          (cand_id),
    .start_score_calc (start_score_calc),
    .start_calc_min   (start_calc_min),
    .done_calc_min    (done_calc_min),
    .score_0          (score_0),
    .score_1          (score_1),
    .id_0             (id_0),
    .id_1             (id_1),
    .min_score_0      (min_score_0),
    .min_score_1      (min_score_1),
    .min_id_0         (min_id_0),
    .min_id_1         (min_id_1),
    .res_valid        (res_valid),
    .res_score_0      (res_score_0),
    .res_score_1      (res_score_1),
    .res_id_0         (res_id_0),
    .res_id_1         (res_id_1),
    .busy             (busy)
  );

  // Free-running clock, period 10.
  always #5 clk = ~clk;

  // Behavioural top-2 minimum calculator: strict less-than replacement.
  typedef struct packed {
    logic [15:0] s0;
    logic [11:0] i0;
    logic [15:0] s1;
    logic [11:0] i1;
  } top2_t;

  function automatic top2_t insert_cand(input top2_t t, input logic [15:0] s, input logic [11:0] id);
    top2_t r;
    r = t;
    if (s < t.s0) begin
      r.s1 = t.s0;
      r.i1 = t.i0;
      r.s0 = s;
      r.i0 = id;
    end else if (s < t.s1) begin
      r.s1 = s;
      r.i1 = id;
    end
    return r;
  endfunction

  top2_t mdl;
  int    dcnt;
  int    done_delay = 1;
  logic  extra_done;

  assign done_calc_min = (dcnt == 1) || extra_done;
  assign min_score_0   = mdl.s0;
  assign min_id_0      = mdl.i0;
  assign min_score_1   = mdl.s1;
  assign min_id_1      = mdl.i1;

  // Calculator model: clear on start_score_calc, compare the pair on start_calc_min, done after done_delay cycles.
  always @(posedge clk or posedge reset_N) begin
    if (reset_N) begin
      mdl  <= '0;
      dcnt <= 0;
    end else begin
      if (start_score_calc) begin
        mdl <= {16'hFFFF, 12'h000, 16'hFFFF, 12'h000};
      end
      if (start_calc_min) begin
        mdl  <= insert_cand(insert_cand(mdl, score_0, id_0), score_1, id_1);
        dcnt <= done_delay;
      end else if (dcnt != 0) begin
        dcnt <= dcnt - 1;
      end
    end
  end

  // Event counters and pair-stability watcher sampled on the rising edge.
  int          n_calc = 0, n_clear = 0, n_res = 0, n_ready = 0, n_busy = 0, n_unstable = 0;
  logic        track = 1'b0;
  logic [55:0] snap;
  logic [15:0] last_s1;
  logic [11:0] last_i1;

  always @(posedge clk) begin
    if (start_calc_min)   n_calc  <= n_calc + 1;
    if (start_score_calc) n_clear <= n_clear + 1;
    if (res_valid)        n_res   <= n_res + 1;
    if (cand_ready)       n_ready <= n_ready + 1;
    if (busy)             n_busy  <= n_busy + 1;
    if (reset_N) begin
      track <= 1'b0;
    end else begin
      if (track && ({score_0, score_1, id_0, id_1} != snap)) n_unstable <= n_unstable + 1;
      if (start_calc_min) begin
        track   <= 1'b1;
        snap    <= {score_0, score_1, id_0, id_1};
        last_s1 <= score_1;
        last_i1 <= id_1;
      end else if (track && done_calc_min) begin
        track <= 1'b0;
      end
    end
  end

  int c_calc, c_clear, c_res, c_ready, c_busy, c_unstable;

  task automatic snapshot();
    c_calc     = n_calc;
    c_clear    = n_clear;
    c_res      = n_res;
    c_ready    = n_ready;
    c_busy     = n_busy;
    c_unstable = n_unstable;
  endtask

  task automatic check_output(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    total++;
    assert (observed === expected) else begin
      bad++;
      $error("FAIL %s observed=%0d expected=%0d", tag, observed, expected);
    end
  endtask

  task automatic start_search(input logic [7:0] n);
    num_candidates    = n;
    start_pair_search = 1'b1;
    @(negedge clk);
    start_pair_search = 1'b0;
  endtask

  task automatic apply_stimulus(input logic [15:0] s, input logic [11:0] id, input int gap);
    int guard;
    repeat (gap) @(negedge clk);
    cand_valid = 1'b1;
    cand_score = s;
    cand_id    = id;
    guard      = 0;
    while (!cand_ready && guard < 200) begin
      @(negedge clk);
      guard++;
    end
    if (!cand_ready) check_output("cand_ready_seen", 32'(cand_ready), 32'd1);
    @(negedge clk);
    cand_valid = 1'b0;
  endtask

  task automatic wait_res();
    int guard;
    guard = 0;
    while (!res_valid && guard < 2000) begin
      @(negedge clk);
      guard++;
    end
    check_output("res_valid_seen", 32'(res_valid), 32'd1);
    @(negedge clk);
    check_output("res_valid_one_cycle", 32'(res_valid), 32'd0);
  endtask

  task automatic check_result(input string tag, input logic [15:0] s0, input logic [11:0] i0,
                              input logic [15:0] s1, input logic [11:0] i1);
    check_output({tag, "_res_score_0"}, 32'(res_score_0), 32'(s0));
    check_output({tag, "_res_id_0"},    32'(res_id_0),    32'(i0));
    check_output({tag, "_res_score_1"}, 32'(res_score_1), 32'(s1));
    check_output({tag, "_res_id_1"},    32'(res_id_1),    32'(i1));
  endtask

  // Watchdog so the run always terminates.
  initial begin
    #3000000;
    $display("[TB] FAIL watchdog expired total=%0d bad=%0d", total, bad);
    $fatal(1, "[TB] watchdog");
  end

  // Directed test sequence.
  initial begin
    reset_N           = 1'b1;
    start_pair_search = 1'b0;
    num_candidates    = '0;
    cand_valid        = 1'b0;
    cand_score        = '0;
    cand_id           = '0;
    extra_done        = 1'b0;
    repeat (2) @(negedge clk);

    $display("[TB] reset state");
    check_output("rst_busy",        32'(busy), 0);
    check_output("rst_cand_ready",  32'(cand_ready), 0);
    check_output("rst_res_valid",   32'(res_valid), 0);
    check_output("rst_start_clear", 32'(start_score_calc), 0);
    check_output("rst_start_min",   32'(start_calc_min), 0);
    check_output("rst_score_0",     32'(score_0), 0);
    check_output("rst_res_score_0", 32'(res_score_0), 0);
    reset_N = 1'b0;
    @(negedge clk);

    $display("[TB] stray done in IDLE");
    snapshot();
    extra_done = 1'b1;
    @(negedge clk);
    extra_done = 1'b0;
    @(negedge clk);
    check_output("stray_done_busy", 32'(busy), 0);
    check_output("stray_done_res",  32'(n_res - c_res), 0);

    $display("[TB] N=4");
    snapshot();
    start_search(8'd4);
    apply_stimulus(16'd30, 12'd1, 0);
    apply_stimulus(16'd10, 12'd2, 0);
    apply_stimulus(16'd20, 12'd3, 0);
    apply_stimulus(16'd5,  12'd4, 0);
    wait_res();
    check_output("n4_calc_pulses", 32'(n_calc - c_calc), 2);
    check_output("n4_clear_pulses", 32'(n_clear - c_clear), 1);
    check_output("n4_res_pulses", 32'(n_res - c_res), 1);
    check_output("n4_busy_cycles", 32'(n_busy - c_busy), 10);
    check_output("n4_busy_after", 32'(busy), 0);
    check_result("n4", 16'd5, 12'd4, 16'd10, 12'd2);

    $display("[TB] N=3 odd pad");
    snapshot();
    start_search(8'd3);
    apply_stimulus(16'd7, 12'd9, 0);
    apply_stimulus(16'd3, 12'd8, 0);
    apply_stimulus(16'd9, 12'd5, 0);
    wait_res();
    check_output("n3_calc_pulses", 32'(n_calc - c_calc), 2);
    check_output("n3_pad_score", 32'(last_s1), 32'hFFFF);
    check_output("n3_pad_id", 32'(last_i1), 0);
    check_result("n3", 16'd3, 12'd8, 16'd7, 12'd9);

    $display("[TB] N=0");
    snapshot();
    start_search(8'd0);
    wait_res();
    check_output("n0_clear_pulses", 32'(n_clear - c_clear), 1);
    check_output("n0_calc_pulses", 32'(n_calc - c_calc), 0);
    check_output("n0_ready_cycles", 32'(n_ready - c_ready), 0);
    check_output("n0_res_pulses", 32'(n_res - c_res), 1);
    check_result("n0", 16'hFFFF, 12'd0, 16'hFFFF, 12'd0);

    $display("[TB] N=2 with gaps and slow done");
    done_delay = 5;
    snapshot();
    start_search(8'd2);
    apply_stimulus(16'd50, 12'd7, 3);
    apply_stimulus(16'd40, 12'd6, 3);
    wait_res();
    check_output("gap_unstable", 32'(n_unstable - c_unstable), 0);
    check_output("gap_res_pulses", 32'(n_res - c_res), 1);
    check_output("gap_calc_pulses", 32'(n_calc - c_calc), 1);
    check_result("gap", 16'd40, 12'd6, 16'd50, 12'd7);

    $display("[TB] reset during WAIT_DONE");
    snapshot();
    start_search(8'd6);
    apply_stimulus(16'd60, 12'd1, 0);
    apply_stimulus(16'd70, 12'd2, 0);
    repeat (2) @(negedge clk);
    check_output("abort_busy_before", 32'(busy), 1);
    reset_N = 1'b1;
    #1;
    check_output("abort_busy", 32'(busy), 0);
    check_output("abort_start_min", 32'(start_calc_min), 0);
    check_output("abort_score_0", 32'(score_0), 0);
    check_output("abort_id_0", 32'(id_0), 0);
    check_output("abort_res_score_0", 32'(res_score_0), 0);
    check_output("abort_res_id_1", 32'(res_id_1), 0);
    @(negedge clk);
    reset_N    = 1'b0;
    done_delay = 1;
    repeat (10) @(negedge clk);
    check_output("abort_no_res", 32'(n_res - c_res), 0);
    check_output("abort_idle", 32'(busy), 0);
    snapshot();
    start_search(8'd2);
    apply_stimulus(16'd12, 12'd3, 0);
    apply_stimulus(16'd11, 12'd4, 0);
    wait_res();
    check_output("post_rst_clear", 32'(n_clear - c_clear), 1);
    check_output("post_rst_res", 32'(n_res - c_res), 1);
    check_result("post_rst", 16'd11, 12'd4, 16'd12, 12'd3);

    $display("[TB] start re-pulsed while busy");
    snapshot();
    start_search(8'd4);
    apply_stimulus(16'd30, 12'd1, 0);
    apply_stimulus(16'd25, 12'd2, 0);
    num_candidates    = 8'd1;
    start_pair_search = 1'b1;
    @(negedge clk);
    start_pair_search = 1'b0;
    apply_stimulus(16'd15, 12'd3, 0);
    apply_stimulus(16'd35, 12'd4, 0);
    wait_res();
    check_output("repulse_calc", 32'(n_calc - c_calc), 2);
    check_output("repulse_res", 32'(n_res - c_res), 1);
    check_result("repulse", 16'd15, 12'd3, 16'd25, 12'd2);

    $display("[TB] N=255");
    snapshot();
    start_search(8'd255);
    for (int i = 0; i < 255; i++) begin
      apply_stimulus(16'(300 - i), 12'(i + 1), 0);
    end
    wait_res();
    check_output("n255_calc", 32'(n_calc - c_calc), 128);
    check_output("n255_res", 32'(n_res - c_res), 1);
    check_output("n255_pad_score", 32'(last_s1), 32'hFFFF);
    check_result("n255", 16'd46, 12'd255, 16'd47, 12'd254);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
